kernel_acc_9: RTL and testbench
===============================

# kernel_acc_9

Consumer-side endpoint of the 3x3 kernel tap sequence in the controller. `counter_9` produces tap indices 0..8 on the issue side; `kernel_acc_9` sits on the receive side. It accepts nine indexed products through a valid/ready handshake and sums them into one window result. It then presents that result downstream with its own valid/ready handshake.

## Interface
- `PROD_W`, 16: width of each signed input product.
- `ACC_W`, `PROD_W+4`: width of the signed window sum. The 4 guard bits cover 9 terms, so the sum never overflows.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tap_valid` input 1: a product is offered this cycle.
- `tap_ready` output 1: the block can accept a product this cycle.
- `tap_idx` input 4: kernel tap index, 0..8, supplied alongside the product.
- `tap_prod` input `PROD_W`: signed product for the offered tap.
- `sum_valid` output 1: `sum_out` holds a completed window.
- `sum_ready` input 1: the downstream stage accepts `sum_out`.
- `sum_out` output `ACC_W`: signed sum of the nine products.
- `seq_err` output 1: one-cycle pulse when a tap arrives out of order.

## Operation
- A tap is accepted only in a cycle where `tap_valid && tap_ready`. A result is taken only in a cycle where `sum_valid && sum_ready`.
- `tap_ready = !rst && (!sum_valid || sum_ready)`. This allows the first tap of the next window to be accepted in the same cycle the previous sum drains.
- Internal state:
  - `acc` (`ACC_W`): running sum.
  - `exp_idx` (4 bit): expected next tap index, range 0..8.
- In-order accepted tap (`tap_idx == exp_idx`), taps 0..7:
  - `acc <= acc + sext(tap_prod)`.
  - `exp_idx <= exp_idx + 1`.
- In-order accepted tap with `exp_idx == 8` (the window closes):
  - `sum_out <= acc + sext(tap_prod)`.
  - `sum_valid <= 1`.
  - `acc <= 0`.
  - `exp_idx <= 0`, wrapping from 8 back to 0.
- Out-of-order accepted tap (`tap_idx != exp_idx`), with checking compiled in (see Configuration):
  - `seq_err` pulses 1 on the next cycle.
  - The partial window is discarded.
  - If `tap_idx == 0`, the tap restarts a new window: `acc <= sext(tap_prod)`, `exp_idx <= 1`.
  - Otherwise the window is cleared: `acc <= 0`, `exp_idx <= 0`.
- A drained sum (`sum_valid && sum_ready`) clears `sum_valid` unless a new window closes in the same cycle; in that case `sum_valid` stays 1 and `sum_out` takes the new sum.
- While `sum_valid && !sum_ready`, `sum_out` is held stable and `tap_ready` is 0.
- Reset (`rst` high at an edge) applies at any point, including mid-window:
  - `acc = 0`, `exp_idx = 0`.
  - `sum_valid = 0`, `sum_out = 0`, `seq_err = 0`.
  - `tap_ready = 0` while `rst` is high.
  - Any partial window is lost.

## Timing
- `sum_valid` rises on the edge that accepts tap 8. It is observable the cycle after that acceptance.
- Throughput with `sum_ready` held at 1: one tap per cycle, continuously. This gives one window per 9 cycles with no bubbles.
- `seq_err` is registered. It is high for exactly the one cycle after the offending acceptance.
- `tap_ready` is combinational from `sum_valid` (registered) and `sum_ready`. There is no combinational path from `tap_valid` to `tap_ready`.

## Configuration
- `KACC_SEQ_CHECK_EN` defined:
  - `tap_idx` is compared against `exp_idx` on every accepted tap.
  - Mismatch handling applies exactly as described in Operation.
- `KACC_SEQ_CHECK_EN` undefined:
  - `tap_idx` is ignored.
  - Every accepted tap is treated as in order; each window closes on the 9th accepted tap.
  - The `seq_err` port remains present, tied to 0.

## Structure
- Shared package `kacc_pkg`:
  - `KACC_TAPS = 9`.
  - `KACC_IDX_W = 4`.
  - `KACC_LAST_IDX = 4'd8`.
  - `KACC_GUARD_W = 4`.
- One sub-module, `kacc_out_stage`:
  - Owns the output register and the handshake: holds `sum_out`/`sum_valid`, generates `tap_ready`, and handles load-while-drain.
  - The accumulator and index tracking stay in the top level.

## Test plan
- After reset, drive taps with idx 0..8 and products 1..9, `sum_ready = 1` → `sum_out = 45`, with `sum_valid` high for one cycle. Check all outputs are 0 during reset.
- Drive nine taps of `tap_prod = -32768` → `sum_out = -294912`, with no overflow in 20 bits. Repeat with nine taps of `+32767` → `294903`.
- Complete a window with `sum_ready = 0` for 5 cycles → `tap_ready = 0` and `sum_out` stable throughout. Then raise `sum_ready` while tap 0 of the next window is offered → the tap is accepted in that cycle.
- Run back-to-back windows with products all 2, then all 3, with `tap_valid` and `sum_ready` tied high → sums 18 then 27, nine cycles apart, with no gap.
- With `KACC_SEQ_CHECK_EN` defined:
  - Send idx 0,1,2,5 → `seq_err` pulses once.
  - Then send idx 0..8 with products all 10 → `sum_out = 90`.
  - Send idx 0,1,0 (the repeated 0 restarts the window), then idx 1..8, all products 1 → `seq_err` pulses once and `sum_out = 9`.
- Assert `rst` after tap 4 of a window, release it, then send idx 0..8 with products 1..9 → `sum_out = 45`, with no carry-over from the aborted window.

Source files
------------

// File: rtl/kacc_pkg.sv
// Shared constants for the 3x3 kernel accumulator (tap count, index width, guard bits).
package kacc_pkg;
    localparam int unsigned KACC_TAPS     = 9;
    localparam int unsigned KACC_IDX_W    = 4;
    localparam logic [3:0]  KACC_LAST_IDX = 4'd8;
    localparam int unsigned KACC_GUARD_W  = 4;
endpackage

// File: rtl/kacc_out_stage.sv
// Output register for kernel_acc_9: holds the window sum, drives the downstream
// valid/ready handshake and the upstream tap_ready, and supports load-while-drain.
module kacc_out_stage
    import kacc_pkg::*;
#(
    parameter int unsigned ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_sum,
    input  logic             sum_ready,
    output logic             sum_valid,
    output logic [ACC_W-1:0] sum_out,
    output logic             tap_ready
);

    // Upstream may proceed whenever the held sum is absent or draining this cycle.
    assign tap_ready = !rst && (!sum_valid || sum_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_valid <= 1'b0;
            sum_out   <= '0;
        end else if (load) begin
            sum_valid <= 1'b1;
            sum_out   <= load_sum;
        end else if (sum_valid && sum_ready) begin
            sum_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/kernel_acc_9.sv
// Receive-side 3x3 kernel accumulator: sums nine indexed products into one window result.
// Optional tap-order checking is enabled with `define KACC_SEQ_CHECK_EN.
module kernel_acc_9
    import kacc_pkg::*;
#(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = PROD_W + KACC_GUARD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tap_valid,
    output logic                  tap_ready,
    input  logic [KACC_IDX_W-1:0] tap_idx,
    input  logic [PROD_W-1:0]     tap_prod,
    output logic                  sum_valid,
    input  logic                  sum_ready,
    output logic [ACC_W-1:0]      sum_out,
    output logic                  seq_err
);

    logic [ACC_W-1:0]      acc;
    logic [KACC_IDX_W-1:0] exp_idx;
    logic [ACC_W-1:0]      prod_ext;
    logic [ACC_W-1:0]      next_sum;
    logic                  accept;
    logic                  in_order;
    logic                  close;

    assign accept   = tap_valid && tap_ready;
    assign prod_ext = {{(ACC_W-PROD_W){tap_prod[PROD_W-1]}}, tap_prod};
    assign next_sum = acc + prod_ext;

`ifdef KACC_SEQ_CHECK_EN
    assign in_order = (tap_idx == exp_idx);
`else
    // Index is not examined in this build; every accepted tap counts in order.
    logic unused_idx;
    assign unused_idx = ^tap_idx;
    assign in_order   = 1'b1;
`endif

    assign close = accept && in_order && (exp_idx == KACC_LAST_IDX);

    // Running sum and expected-index tracking; out-of-order taps discard the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            exp_idx <= '0;
        end else if (accept) begin
            if (in_order) begin
                if (exp_idx == KACC_LAST_IDX) begin
                    acc     <= '0;
                    exp_idx <= '0;
                end else begin
                    acc     <= next_sum;
                    exp_idx <= exp_idx + KACC_IDX_W'(1);
                end
            end else if (tap_idx == '0) begin
                acc     <= prod_ext;
                exp_idx <= KACC_IDX_W'(1);
            end else begin
                acc     <= '0;
                exp_idx <= '0;
            end
        end
    end

`ifdef KACC_SEQ_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_err <= 1'b0;
        end else begin
            seq_err <= accept && !in_order;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

    kacc_out_stage #(
        .ACC_W(ACC_W)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (close),
        .load_sum (next_sum),
        .sum_ready(sum_ready),
        .sum_valid(sum_valid),
        .sum_out  (sum_out),
        .tap_ready(tap_ready)
    );

endmodule

// File: tb/tb_kernel_acc_9.sv
// Scoreboard bench for kernel_acc_9: expected window sums are queued when a window
// is driven and compared when the DUT hands the sum downstream.
module tb_kernel_acc_9;

    localparam int unsigned PROD_W = 16;
    localparam int unsigned ACC_W  = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              tap_valid;
    logic              tap_ready;
    logic [3:0]        tap_idx;
    logic [PROD_W-1:0] tap_prod;
    logic              sum_valid;
    logic              sum_ready;
    logic [ACC_W-1:0]  sum_out;
    logic              seq_err;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned cyc    = 0;

    logic [ACC_W-1:0] exp_q[$];
    int unsigned      pop_cyc[$];

    kernel_acc_9 #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tap_valid(tap_valid),
        .tap_ready(tap_ready),
        .tap_idx  (tap_idx),
        .tap_prod (tap_prod),
        .sum_valid(sum_valid),
        .sum_ready(sum_ready),
        .sum_out  (sum_out),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Compare every sum taken downstream against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && sum_valid && sum_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected_sum", 32'(sum_out), 32'hdead_beef);
            else check("sum_out", 32'(sum_out), 32'(exp_q.pop_front()));
        end
    end

    task automatic send_tap(input logic [3:0] idx, input logic [PROD_W-1:0] prod);
        int budget = 0;
        tap_valid = 1'b1;
        tap_idx   = idx;
        tap_prod  = prod;
        @(negedge clk);
        while (!tap_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!tap_ready) check("tap_accept_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        tap_valid = 1'b0;
    endtask

    task automatic send_window(input logic [PROD_W-1:0] prod, input logic [ACC_W-1:0] exp);
        exp_q.push_back(exp);
        for (int i = 0; i < 9; i++) send_tap(4'(i), prod);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n0;
        rst       = 1'b1;
        tap_valid = 1'b0;
        tap_idx   = '0;
        tap_prod  = '0;
        sum_ready = 1'b1;

        // Outputs during reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tap_ready", 32'(tap_ready), 32'(0));
        check("rst_sum_valid", 32'(sum_valid), 32'(0));
        check("rst_sum_out",   32'(sum_out),   32'(0));
        check("rst_seq_err",   32'(seq_err),   32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Products 1..9 -> 45, valid for a single cycle.
        exp_q.push_back(20'(45));
        for (int i = 0; i < 9; i++) send_tap(4'(i), 16'(i + 1));
        @(negedge clk);
        @(negedge clk);
        check("valid_one_cycle", 32'(sum_valid), 32'(0));
        @(posedge clk);
        #1;

        // Extremes: no overflow in the 20-bit sum.
        send_window(16'h8000, 20'(-294912));
        send_window(16'h7fff, 20'(294903));
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: sum held, tap_ready low.
        sum_ready = 1'b0;
        send_window(16'(7), 20'(63));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_tap_ready", 32'(tap_ready), 32'(0));
            check("bp_sum_valid", 32'(sum_valid), 32'(1));
            check("bp_sum_out",   32'(sum_out),   32'(63));
        end
        @(posedge clk);
        #1;
        tap_valid = 1'b1;
        tap_idx   = 4'd0;
        tap_prod  = 16'(4);
        sum_ready = 1'b1;
        @(negedge clk);
        check("drain_accept_ready", 32'(tap_ready), 32'(1));
        @(posedge clk);
        #1;
        tap_valid = 1'b0;
        exp_q.push_back(20'(36));
        for (int i = 1; i < 9; i++) send_tap(4'(i), 16'(4));
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back streaming windows: 18 then 27, nine cycles apart.
        n0 = pop_cyc.size();
        exp_q.push_back(20'(18));
        exp_q.push_back(20'(27));
        for (int w = 0; w < 2; w++) begin
            for (int t = 0; t < 9; t++) begin
                tap_valid = 1'b1;
                tap_idx   = 4'(t);
                tap_prod  = (w == 0) ? 16'(2) : 16'(3);
                @(negedge clk);
                check("stream_ready", 32'(tap_ready), 32'(1));
                @(posedge clk);
                #1;
            end
        end
        tap_valid = 1'b0;
        repeat (2) @(negedge clk);
        if (pop_cyc.size() >= n0 + 2) check("stream_gap", pop_cyc[n0+1] - pop_cyc[n0], 32'(9));
        else check("stream_pops", 32'(pop_cyc.size() - n0), 32'(2));
        @(posedge clk);
        #1;

`ifdef KACC_SEQ_CHECK_EN
        // Out-of-order index 5 aborts the window.
        send_tap(4'd0, 16'(1));
        send_tap(4'd1, 16'(1));
        send_tap(4'd2, 16'(1));
        send_tap(4'd5, 16'(1));
        @(negedge clk);
        check("seq_err_pulse", 32'(seq_err), 32'(1));
        @(negedge clk);
        check("seq_err_clear", 32'(seq_err), 32'(0));
        @(posedge clk);
        #1;
        send_window(16'(10), 20'(90));
        // Repeated 0 restarts the window.
        exp_q.push_back(20'(9));
        send_tap(4'd0, 16'(1));
        send_tap(4'd1, 16'(1));
        send_tap(4'd0, 16'(1));
        @(negedge clk);
        check("restart_seq_err", 32'(seq_err), 32'(1));
        @(posedge clk);
        #1;
        for (int i = 1; i < 9; i++) send_tap(4'(i), 16'(1));
        @(negedge clk);
        check("restart_no_err", 32'(seq_err), 32'(0));
        @(posedge clk);
        #1;
`endif

        // Reset mid-window discards the partial sum.
        for (int i = 0; i < 5; i++) send_tap(4'(i), 16'(100));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tap_ready", 32'(tap_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(20'(45));
        for (int i = 0; i < 9; i++) send_tap(4'(i), 16'(i + 1));

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        check("final_seq_err", 32'(seq_err), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
